// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the instruction-fetch stage: boot/trap vectors and FSM encoding.
package instr_fetch_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] CPU_IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] CPU_EXC_VEC  = 32'h8000_0008;

    // StWait: request outstanding (or about to issue) for pc
    // StHold: fetched instruction buffered while the decoder stalls
    // StDrop: outstanding request belongs to a pc we redirected away from
    typedef enum logic [1:0] {
        StWait = 2'd0,
        StHold = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-pc priority selector: exc > irq (user mode only) > jr > jump > branch > pc+4.
module pc_next_sel
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = CPU_IRQ_VEC,
    parameter logic [31:0] EXC_VEC = CPU_EXC_VEC
) (
    input  logic [31:0] pc,
    input  logic        exc,
    input  logic        irq,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] seq_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        irq_taken
);

    logic [31:0] target;

    // pc+4 wraps naturally in 32 bits
    assign seq_pc = word_align(pc + 32'd4);

    // Priority encode the redirect sources; pc[31] set means kernel mode, where irq is masked
    always_comb begin
        redirect  = 1'b1;
        irq_taken = 1'b0;
        target    = seq_pc;
        if (exc) begin
            target = EXC_VEC;
        end else if (irq && !pc[31]) begin
            target    = IRQ_VEC;
            irq_taken = 1'b1;
        end else if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = jump_target;
        end else if (branch_taken) begin
            target = branch_target;
        end else begin
            redirect = 1'b0;
        end
    end

    assign redirect_pc = word_align(target);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding imem handshake, stall buffering and redirects.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC,
    parameter logic [31:0] IRQ_VEC  = CPU_IRQ_VEC,
    parameter logic [31:0] EXC_VEC  = CPU_EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        upd_pc,
    output logic        flush,
    output logic        irq_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;     // issue a request for pc_q this cycle
    logic         out_q, out_d;     // a request was issued in an earlier cycle, ack pending
    logic         boot_q;           // first request after reset release
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  ifpc_q, ifpc_d;

    logic [31:0]  seq_pc;
    logic [31:0]  redirect_pc;
    logic         redirect;
    logic         irq_taken;
    logic         ack_ok;

    pc_next_sel #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_pc_next_sel (
        .pc            (pc_q),
        .exc           (exc),
        .irq           (irq),
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .seq_pc        (seq_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .irq_taken     (irq_taken)
    );

    // Acks are only meaningful for a request issued in an earlier cycle; this also
    // drops stray acks from a request abandoned by reset.
    assign ack_ok    = imem_ack & out_q;
    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    // State, pc and buffered-instruction registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StWait;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            out_q   <= 1'b0;
            boot_q  <= 1'b1;
            inst_q  <= 32'd0;
            ifpc_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            out_q   <= out_d;
            boot_q  <= 1'b0;
            inst_q  <= inst_d;
            ifpc_q  <= ifpc_d;
        end
    end

    // Next-state logic, request scheduling and IF2ID outputs
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = boot_q;
        out_d   = out_q | req_q;
        inst_d  = inst_q;
        ifpc_d  = ifpc_q;
        upd_pc  = 1'b0;
        flush   = redirect;
        irq_out = irq_taken;
        if_inst = inst_q;
        if_pc   = ifpc_q;

        if (ack_ok) begin
            out_d = 1'b0;
        end

        unique case (state_q)
            StWait: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    // Anything still in flight is now stale and must be drained first
                    if (ack_ok || !(out_q || req_q)) begin
                        req_d = 1'b1;
                    end else begin
                        state_d = StDrop;
                    end
                end else if (ack_ok) begin
                    inst_d  = imem_rdata;
                    ifpc_d  = seq_pc;
                    if_inst = imem_rdata;
                    if_pc   = seq_pc;
                    if (stall) begin
                        state_d = StHold;
                    end else begin
                        upd_pc = 1'b1;
                        pc_d   = seq_pc;
                        req_d  = 1'b1;
                    end
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    req_d   = 1'b1;
                    state_d = StWait;
                end else if (!stall) begin
                    upd_pc  = 1'b1;
                    pc_d    = seq_pc;
                    req_d   = 1'b1;
                    state_d = StWait;
                end
            end
            StDrop: begin
                // Latest redirect target wins while draining
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (ack_ok) begin
                    req_d   = 1'b1;
                    state_d = StWait;
                end
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a request/delivery scoreboard and a simple imem model.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        irq;
    logic        exc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        upd_pc;
    logic        flush;
    logic        irq_out;

    int errors;
    int checks;

    // Scoreboard: expected request addresses and expected {if_pc, if_inst} deliveries
    logic [31:0] exp_req[$];
    logic [63:0] exp_del[$];

    // Memory model state
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;

    instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .irq           (irq),
        .exc           (exc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .upd_pc        (upd_pc),
        .flush         (flush),
        .irq_out       (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_del(input logic [31:0] pc4, input logic [31:0] inst);
        exp_del.push_back({pc4, inst});
    endtask

    // Runs at the negedge: score requests and deliveries, latch requests into the memory
    task automatic mon();
        logic [63:0] d;
        if (imem_req === 1'b1) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = mem_lat;
            chk("req_expected", {31'd0, exp_req.size() != 0}, 32'd1);
            if (exp_req.size() != 0) chk("req_addr", imem_addr, exp_req.pop_front());
        end
        if (upd_pc === 1'b1) begin
            chk("upd_expected", {31'd0, exp_del.size() != 0}, 32'd1);
            if (exp_del.size() != 0) begin
                d = exp_del.pop_front();
                chk("del_if_pc", if_pc, d[63:32]);
                chk("del_if_inst", if_inst, d[31:0]);
            end
        end
    endtask

    // Runs just after the posedge: drive the ack for this cycle
    task automatic mem_step();
        imem_ack = 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(mem_addr);
                mem_pend   = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic rest();
        mon();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic tick();
        half();
        rest();
    endtask

    task automatic drained(input string tag);
        chk({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
        chk({tag, "_del_left"}, 32'(exp_del.size()), 32'd0);
    endtask

    task automatic clear_ctl();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        irq          = 1'b0;
        exc          = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        stall = 1'b0;
        clear_ctl();
        branch_target = 32'd0;
        jump_target   = 32'd0;
        jr_target     = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        mem_pend = 1'b0;
        mem_addr = 32'd0;
        mem_cnt  = 0;
        mem_lat  = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        half();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_pc", if_pc, 32'h8000_0000);
        chk("rst_upd_pc", {31'd0, upd_pc}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_irq_out", {31'd0, irq_out}, 32'd0);
        rest();
        reset = 1'b1;
        tick();

        // Sequential fetch from the reset vector, ack latency 1
        push_req(32'h8000_0000);
        push_del(32'h8000_0004, mem_data(32'h8000_0000));
        push_req(32'h8000_0004);
        push_del(32'h8000_0008, mem_data(32'h8000_0004));
        push_req(32'h8000_0008);
        repeat (5) tick();
        drained("boot");

        // Stall high for three cycles starting at the ack
        stall = 1'b1;
        half(); chk("hold0_upd", {31'd0, upd_pc}, 32'd0); rest();
        half(); chk("hold1_upd", {31'd0, upd_pc}, 32'd0);
        chk("hold1_inst", if_inst, mem_data(32'h8000_0008)); rest();
        half(); chk("hold2_upd", {31'd0, upd_pc}, 32'd0); rest();
        stall = 1'b0;
        push_del(32'h8000_000C, mem_data(32'h8000_0008));
        half(); chk("hold_release_upd", {31'd0, upd_pc}, 32'd1); rest();
        push_req(32'h8000_000C);
        mem_lat = 2;
        tick();
        mem_lat = 0;

        // Branch while a request is outstanding: stale ack dropped
        branch_taken = 1'b1; branch_target = 32'h0040_0010;
        half(); chk("br_flush", {31'd0, flush}, 32'd1); rest();
        clear_ctl();
        tick();
        half(); chk("stale_ack_upd", {31'd0, upd_pc}, 32'd0); rest();
        push_req(32'h0040_0010);
        tick();
        push_del(32'h0040_0014, mem_data(32'h0040_0010));
        push_req(32'h0040_0014);
        push_del(32'h0040_0018, mem_data(32'h0040_0014));
        push_req(32'h0040_0018);
        push_del(32'h0040_001C, mem_data(32'h0040_0018));
        push_req(32'h0040_001C);
        push_del(32'h0040_0020, mem_data(32'h0040_001C));
        push_req(32'h0040_0020);
        repeat (8) tick();
        drained("branch");

        // User-mode irq coinciding with the ack
        irq = 1'b1;
        half();
        chk("irq_flush", {31'd0, flush}, 32'd1);
        chk("irq_out_user", {31'd0, irq_out}, 32'd1);
        chk("irq_ack_upd", {31'd0, upd_pc}, 32'd0);
        rest();
        clear_ctl();
        push_req(32'h8000_0004);
        tick();
        jump = 1'b1; jump_target = 32'h8000_0100;
        half();
        chk("jump_flush", {31'd0, flush}, 32'd1);
        chk("jump_irq_out", {31'd0, irq_out}, 32'd0);
        rest();
        clear_ctl();
        push_req(32'h8000_0100);
        tick();
        // Kernel-mode irq is ignored
        irq = 1'b1;
        push_del(32'h8000_0104, mem_data(32'h8000_0100));
        half();
        chk("kirq_flush", {31'd0, flush}, 32'd0);
        chk("kirq_irq_out", {31'd0, irq_out}, 32'd0);
        rest();
        clear_ctl();
        push_req(32'h8000_0104);
        tick();
        drained("irq");

        // jr beats jump and branch
        jr = 1'b1; jr_target = 32'h0040_0200;
        jump = 1'b1; jump_target = 32'h0040_0300;
        branch_taken = 1'b1; branch_target = 32'h0040_0400;
        half(); chk("jr_flush", {31'd0, flush}, 32'd1); rest();
        clear_ctl();
        push_req(32'h0040_0200);
        tick();
        // exc beats irq and jump
        exc = 1'b1; irq = 1'b1; jump = 1'b1;
        half();
        chk("exc_flush", {31'd0, flush}, 32'd1);
        chk("exc_irq_out", {31'd0, irq_out}, 32'd0);
        rest();
        clear_ctl();
        push_req(32'h8000_0008);
        tick();
        // Redirect in HOLD overrides the stall
        stall = 1'b1;
        half(); chk("hold_b_upd", {31'd0, upd_pc}, 32'd0); rest();
        branch_taken = 1'b1; branch_target = 32'h0040_0040;
        half();
        chk("hold_br_flush", {31'd0, flush}, 32'd1);
        chk("hold_br_upd", {31'd0, upd_pc}, 32'd0);
        rest();
        clear_ctl();
        stall = 1'b0;
        push_req(32'h0040_0040);
        tick();
        // irq beats jr in user mode
        irq = 1'b1; jr = 1'b1; jr_target = 32'h0040_0500;
        half(); chk("irq_over_jr", {31'd0, irq_out}, 32'd1); rest();
        clear_ctl();
        push_req(32'h8000_0004);
        tick();
        push_del(32'h8000_0008, mem_data(32'h8000_0004));
        push_req(32'h8000_0008);
        tick();
        tick();
        drained("prio");

        // Wrap at the top of the address space; low target bits forced to zero
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        half(); chk("wrap_jump_flush", {31'd0, flush}, 32'd1); rest();
        clear_ctl();
        push_req(32'hFFFF_FFFC);
        tick();
        push_del(32'h0000_0000, mem_data(32'hFFFF_FFFC));
        half(); chk("wrap_if_pc", if_pc, 32'h0000_0000); rest();
        push_req(32'h0000_0000);
        tick();
        push_del(32'h0000_0004, mem_data(32'h0000_0000));
        tick();
        push_req(32'h0000_0004);
        mem_lat = 2;
        tick();
        mem_lat = 0;

        // Two redirects while draining: latest target wins
        branch_taken = 1'b1; branch_target = 32'h0040_0600;
        half(); chk("drop_br_flush", {31'd0, flush}, 32'd1); rest();
        clear_ctl();
        jump = 1'b1; jump_target = 32'h0040_0700;
        half(); chk("drop_jump_flush", {31'd0, flush}, 32'd1); rest();
        clear_ctl();
        half(); chk("drop_ack_upd", {31'd0, upd_pc}, 32'd0); rest();
        push_req(32'h0040_0700);
        tick();
        push_del(32'h0040_0704, mem_data(32'h0040_0700));
        push_req(32'h0040_0704);
        tick();
        mem_lat = 1;
        tick();
        mem_lat = 0;
        drained("drop");

        // Reset with a request outstanding; the late ack lands after release
        reset = 1'b0;
        half();
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_if_pc", if_pc, 32'h8000_0000);
        chk("mid_rst_if_inst", if_inst, 32'd0);
        chk("mid_rst_upd", {31'd0, upd_pc}, 32'd0);
        rest();
        reset = 1'b1;
        half();
        chk("late_ack_upd", {31'd0, upd_pc}, 32'd0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);
        rest();
        push_req(32'h8000_0000);
        tick();
        push_del(32'h8000_0004, mem_data(32'h8000_0000));
        tick();
        push_req(32'h8000_0004);
        tick();
        drained("rereset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
